io_switch_debounce: RTL and testbench

- Input-conditioning stage directly upstream of the CPU's I/O input port latch.
- Takes raw asynchronous board switch/key levels for two input ports, synchronises them into the CPU clock domain, and debounces them per port.
- Presents each port as a stable 32-bit zero-extended word ready to be latched and read back by the CPU's memory-mapped I/O read path.
- Also emits a one-cycle change pulse per port.

---
 rtl/io_switch_debounce.sv | 84 ++++++++
 tb/tb_io_switch_debounce.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/io_switch_debounce.sv
// io_switch_debounce
// Input conditioning for the CPU's two I/O input ports. Each port takes raw
// asynchronous switch levels, passes them through a two-flop synchroniser and
// debounces the whole word. A new value is accepted only after it has been
// stable for DB_CYCLES consecutive cycles. Each port then presents the
// debounced value as a zero-extended 32-bit word, along with a one-cycle
// change pulse. Every output comes straight from a register.

module io_switch_debounce #(
    parameter int SW_WIDTH  = 5,
    parameter int DB_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [SW_WIDTH-1:0] sw0,
    input  logic [SW_WIDTH-1:0] sw1,
    output logic [31:0]         in_port0,
    output logic [31:0]         in_port1,
    output logic                changed0,
    output logic                changed1
);

    // The counter only ever reaches DB_CYCLES-1, so clog2(DB_CYCLES) bits are enough.
    localparam int                CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    // Two identical, independent port instances.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [SW_WIDTH-1:0] raw;
        logic [SW_WIDTH-1:0] s1;
        logic [SW_WIDTH-1:0] s2;
        logic [SW_WIDTH-1:0] prev;
        logic [SW_WIDTH-1:0] stable;
        logic [CNT_W-1:0]    cnt;
        logic                chg;

        assign raw = (p == 0) ? sw0 : sw1;

        // Two-flop synchroniser plus a one-cycle history of the synchronised word.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                s1   <= '0;
                s2   <= '0;
                prev <= '0;
            end else begin
                s1   <= raw;
                s2   <= s1;
                prev <= s2;
            end
        end

        // Whole-word qualification. Any bit moving restarts the count, so a
        // multi-bit change is accepted all at once. A return to the accepted
        // value simply drops the pending change.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                cnt    <= '0;
                stable <= '0;
                chg    <= 1'b0;
            end else begin
                chg <= 1'b0;
                if (s2 != prev) begin
                    cnt <= '0;
                end else if (s2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    stable <= s2;
                    cnt    <= '0;
                    chg    <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    // Zero-extension is wiring only, so each output stays a pure register output.
    assign in_port0 = 32'(g_port[0].stable);
    assign in_port1 = 32'(g_port[1].stable);
    assign changed0 = g_port[0].chg;
    assign changed1 = g_port[1].chg;

endmodule

// File: tb/tb_io_switch_debounce.sv
// Directed bench for io_switch_debounce with SW_WIDTH=5, DB_CYCLES=4.
// Inputs change 1 ns after a rising edge, so the first sampling edge is the
// next rising edge. Outputs are read 1 ns after each rising edge.

module tb_io_switch_debounce;

    localparam int SW_WIDTH  = 5;
    localparam int DB_CYCLES = 4;

    logic                clock  = 1'b0;
    logic                resetn = 1'b0;
    logic [SW_WIDTH-1:0] sw0    = '0;
    logic [SW_WIDTH-1:0] sw1    = '0;
    logic [31:0]         in_port0;
    logic [31:0]         in_port1;
    logic                changed0;
    logic                changed1;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulses0      = 0;
    int pulses1      = 0;
    int p0_mark;
    int p1_mark;

    io_switch_debounce #(
        .SW_WIDTH (SW_WIDTH),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .sw0     (sw0),
        .sw1     (sw1),
        .in_port0(in_port0),
        .in_port1(in_port1),
        .changed0(changed0),
        .changed1(changed1)
    );

    // Clock: 10 ns period.
    always #5 clock = ~clock;

    // Count change pulses, sampled mid-cycle.
    always @(negedge clock) begin
        if (changed0) pulses0 = pulses0 + 1;
        if (changed1) pulses1 = pulses1 + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs were just driven. Expect six quiet edges, then acceptance with
    // its pulse on the seventh, then the pulse dropping on the eighth.
    task automatic settle(input logic [4:0] old0, input logic [4:0] new0,
                          input logic [4:0] old1, input logic [4:0] new1);
        for (int i = 0; i < DB_CYCLES + 2; i++) begin
            tick();
            check("quiet_port0", in_port0, {27'b0, old0});
            check("quiet_port1", in_port1, {27'b0, old1});
            check("quiet_chg0", {31'b0, changed0}, 32'd0);
            check("quiet_chg1", {31'b0, changed1}, 32'd0);
        end
        tick();
        check("accept_port0", in_port0, {27'b0, new0});
        check("accept_port1", in_port1, {27'b0, new1});
        check("accept_chg0", {31'b0, changed0}, {31'b0, (old0 != new0)});
        check("accept_chg1", {31'b0, changed1}, {31'b0, (old1 != new1)});
        tick();
        check("after_port0", in_port0, {27'b0, new0});
        check("after_port1", in_port1, {27'b0, new1});
        check("after_chg0", {31'b0, changed0}, 32'd0);
        check("after_chg1", {31'b0, changed1}, 32'd0);
    endtask

    initial begin
        // Power-on reset.
        repeat (2) tick();
        check("rst_port0", in_port0, 32'h0);
        check("rst_port1", in_port1, 32'h0);
        check("rst_chg0", {31'b0, changed0}, 32'd0);
        resetn = 1'b1;

        // Bring port 0 up to 1F so the asynchronous reset has something to clear.
        sw0 = 5'h1F;
        p0_mark = pulses0;
        settle(5'h00, 5'h1F, 5'h00, 5'h00);
        check("pre_pulses0", pulses0, p0_mark + 1);

        // 1. Reset mid-cycle clears outputs immediately; then a full requalification.
        #2 resetn = 1'b0;
        #1;
        check("async_rst_port0", in_port0, 32'h0);
        check("async_rst_chg0", {31'b0, changed0}, 32'd0);
        tick();
        check("held_rst_port0", in_port0, 32'h0);
        resetn = 1'b1;
        p0_mark = pulses0;
        settle(5'h00, 5'h1F, 5'h00, 5'h00);
        check("t1_pulses0", pulses0, p0_mark + 1);

        // 4. Third-value bounce: 03 for 2 cycles, then 07 is held.
        p0_mark = pulses0;
        sw0 = 5'h03;
        repeat (2) begin
            tick();
            check("t4_bounce_port0", in_port0, 32'h1F);
        end
        sw0 = 5'h07;
        settle(5'h1F, 5'h07, 5'h00, 5'h00);
        check("t4_pulses0", pulses0, p0_mark + 1);

        // Return port 0 to 0 for the glitch tests.
        sw0 = 5'h00;
        settle(5'h07, 5'h00, 5'h00, 5'h00);

        // 2. A 3-cycle glitch, and a glitch of exactly DB_CYCLES cycles, are both rejected.
        p0_mark = pulses0;
        sw0 = 5'h04;
        repeat (3) tick();
        sw0 = 5'h00;
        repeat (10) begin
            tick();
            check("t2_glitch3_port0", in_port0, 32'h0);
        end
        sw0 = 5'h04;
        repeat (DB_CYCLES) tick();
        sw0 = 5'h00;
        repeat (10) begin
            tick();
            check("t2_glitch4_port0", in_port0, 32'h0);
        end
        check("t2_pulses0", pulses0, p0_mark);

        // A pulse of DB_CYCLES+1 cycles is the shortest one that is accepted.
        sw0 = 5'h04;
        repeat (DB_CYCLES + 1) tick();
        sw0 = 5'h00;
        tick();
        check("t2_edge_quiet", in_port0, 32'h0);
        tick();
        check("t2_edge_accept", in_port0, 32'h04);
        check("t2_edge_chg0", {31'b0, changed0}, 32'd1);
        repeat (10) tick();
        check("t2_edge_return", in_port0, 32'h0);

        // 3. Bounce port 1 between 0 and 0A every 2 cycles, then hold 0A.
        p1_mark = pulses1;
        for (int i = 0; i < 10; i++) begin
            sw1 = (i % 2 == 0) ? 5'h0A : 5'h00;
            repeat (2) begin
                tick();
                check("t3_bounce_port1", in_port1, 32'h0);
            end
        end
        sw1 = 5'h0A;
        settle(5'h00, 5'h00, 5'h00, 5'h0A);
        check("t3_pulses1", pulses1, p1_mark + 1);

        // 5. Both ports change on the same edge.
        p0_mark = pulses0;
        p1_mark = pulses1;
        sw0 = 5'h11;
        sw1 = 5'h02;
        settle(5'h00, 5'h11, 5'h0A, 5'h02);
        check("t5_pulses0", pulses0, p0_mark + 1);
        check("t5_pulses1", pulses1, p1_mark + 1);

        // 6. Reset in the middle of qualifying 1F on port 1.
        sw1 = 5'h1F;
        repeat (3) begin
            tick();
            check("t6_pending_port1", in_port1, 32'h02);
        end
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_port1", in_port1, 32'h0);
        check("t6_rst_port0", in_port0, 32'h0);
        tick();
        resetn = 1'b1;
        p1_mark = pulses1;
        settle(5'h00, 5'h11, 5'h00, 5'h1F);
        check("t6_pulses1", pulses1, p1_mark + 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
